serial_seq_gen: RTL and testbench

- Serial stimulus transmitter: the driving end of the single-bit `j` interface consumed by the Mealy/Moore sequence-detector FSMs.
- Latches a programmable bit pattern, shifts it out MSB-first one bit per clock, and repeats it a programmed number of passes.
- Counts detector hits (`w`) observed during the transmission.
- Used as a synthesizable self-driving source for on-chip detector checks, replacing hand-timed bench stimulus.

---
 rtl/serial_seq_gen_if.sv | 29 ++
 rtl/serial_seq_gen.sv | 146 ++++++++++++++
 tb/tb_serial_seq_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_seq_gen_if.sv
// Bus between a serial pattern source and the sequence detector it drives.
// The master side issues commands and feeds back w; the slave side is the transmitter.
interface serial_seq_gen_if #(
  parameter int MAXLEN = 16,
  parameter int LW     = 5,
  parameter int RW     = 4,
  parameter int CW     = 8
);
  logic              start;
  logic [MAXLEN-1:0] pattern;
  logic [LW-1:0]     len;
  logic [RW-1:0]     reps;
  logic              w;
  logic              j;
  logic              j_valid;
  logic              busy;
  logic              done;
  logic [CW-1:0]     hit_count;

  modport master (
    output start, pattern, len, reps, w,
    input  j, j_valid, busy, done, hit_count
  );

  modport slave (
    input  start, pattern, len, reps, w,
    output j, j_valid, busy, done, hit_count
  );
endinterface

// File: rtl/serial_seq_gen.sv
// Serial stimulus transmitter: shifts a latched pattern out MSB-first for a
// programmed number of passes and counts detector hits seen on w.
module serial_seq_gen #(
  parameter int   MAXLEN     = 16,
  parameter int   LW         = 5,
  parameter int   RW         = 4,
  parameter int   CW         = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  serial_seq_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     reps_q, reps_d;
  logic [RW-1:0]     pass_q, pass_d;
  logic              j_q, j_d;
  logic              j_valid_q, j_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW-1:0]     hit_q, hit_d;

  logic [LW-1:0]     eff_len;
  logic [RW-1:0]     eff_reps;
  logic [MAXLEN-1:0] shifted;

  always_comb begin
    eff_len  = (bus.len > LW'(MAXLEN)) ? LW'(MAXLEN) : bus.len;
    eff_reps = (bus.reps == '0) ? RW'(1) : bus.reps;
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    reps_d    = reps_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    j_d       = IDLE_LEVEL;
    j_valid_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    shifted   = '0;

    // w is sampled in DONE too, to catch a Moore detector's lag after the final bit
    if ((state_q == SEND || state_q == DONE) && bus.w && (hit_q != '1)) begin
      hit_d = hit_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d  = bus.pattern;
          len_d  = eff_len;
          reps_d = eff_reps;
          pass_d = RW'(1);
          hit_d  = '0;
          busy_d = 1'b1;
          if (eff_len != '0) begin
            state_d   = SEND;
            idx_d     = eff_len - LW'(1);
            shifted   = bus.pattern >> idx_d;
            j_d       = shifted[0];
            j_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      SEND: begin
        if (idx_q == '0) begin
          if (pass_q < reps_q) begin
            idx_d     = len_q - LW'(1);
            pass_d    = pass_q + RW'(1);
            shifted   = pat_q >> idx_d;
            j_d       = shifted[0];
            j_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d     = idx_q - LW'(1);
          shifted   = pat_q >> idx_d;
          j_d       = shifted[0];
          j_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      j_q       <= IDLE_LEVEL;
      j_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      j_q       <= j_d;
      j_valid_q <= j_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
    end
  end

  assign bus.j         = j_q;
  assign bus.j_valid   = j_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hit_count = hit_q;

endmodule

// File: tb/tb_serial_seq_gen.sv
// Directed bench for serial_seq_gen: expected bits are queued from a pattern model
// when a transmission is requested and popped as the DUT presents valid bits.
module tb_serial_seq_gen;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic expQ[$];

  always #5 clk = ~clk;

  serial_seq_gen_if #(.MAXLEN(16), .LW(5), .RW(4), .CW(8)) bus ();
  serial_seq_gen_if #(.MAXLEN(16), .LW(5), .RW(5), .CW(8)) bus2 ();

  serial_seq_gen #(.MAXLEN(16), .LW(5), .RW(4), .CW(8), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Second instance with wider reps so one transmission outlasts the hit counter range
  serial_seq_gen #(.MAXLEN(16), .LW(5), .RW(5), .CW(8), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transmission starting at the current negedge; returns at the first IDLE negedge
  task automatic applyStimulus(input logic [15:0] pat, input logic [4:0] ln, input logic [3:0] rp,
                               input int wSend, input bit wDone, input bit holdStart,
                               input string name);
    int effLen, effReps, total, expHits, validSeen;
    bit finished;
    effLen  = (ln > 5'd16) ? 16 : int'(ln);
    effReps = (rp == 4'd0) ? 1 : int'(rp);
    total   = effLen * effReps;
    expQ.delete();
    for (int r = 0; r < effReps; r++)
      for (int i = effLen - 1; i >= 0; i--)
        expQ.push_back(pat[i]);
    expHits   = ((wSend < total) ? wSend : total) + (wDone ? 1 : 0);
    validSeen = 0;
    finished  = 1'b0;

    bus.pattern = pat;
    bus.len     = ln;
    bus.reps    = rp;
    bus.w       = 1'b0;
    bus.start   = 1'b1;

    for (int cyc = 1; cyc <= total + 4; cyc++) begin
      @(negedge clk);
      bus.start   = holdStart;
      bus.pattern = ~pat;
      bus.len     = 5'd3;
      bus.reps    = 4'd7;
      checkOutput({name, " busy"}, bus.busy, 1);
      if (cyc == 1) checkOutput({name, " hit_clr"}, bus.hit_count, 0);
      if (bus.j_valid) begin
        if (expQ.size() == 0) checkOutput({name, " extra_bit"}, validSeen + 1, total);
        else checkOutput({name, " j"}, bus.j, expQ.pop_front());
        bus.w = (validSeen < wSend);
        validSeen++;
      end else if (bus.done) begin
        checkOutput({name, " done_at"}, cyc, total + 1);
        checkOutput({name, " bits"}, validSeen, total);
        checkOutput({name, " j_idle"}, bus.j, 0);
        bus.w    = wDone;
        finished = 1'b1;
        break;
      end else begin
        checkOutput({name, " j_valid"}, bus.j_valid, 1);
      end
    end

    checkOutput({name, " done_seen"}, finished, 1);
    if (finished) begin
      @(negedge clk);
      bus.w = 1'b0;
      checkOutput({name, " done_pulse"}, bus.done, 0);
      checkOutput({name, " busy_off"}, bus.busy, 0);
      checkOutput({name, " idle_valid"}, bus.j_valid, 0);
      checkOutput({name, " idle_j"}, bus.j, 0);
      checkOutput({name, " hits"}, bus.hit_count, expHits);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.pattern  = '0;
    bus.len      = '0;
    bus.reps     = '0;
    bus.w        = 1'b0;
    bus2.start   = 1'b0;
    bus2.pattern = '0;
    bus2.len     = '0;
    bus2.reps    = '0;
    bus2.w       = 1'b0;

    #12;
    checkOutput("rst j", bus.j, 0);
    checkOutput("rst j_valid", bus.j_valid, 0);
    checkOutput("rst busy", bus.busy, 0);
    checkOutput("rst done", bus.done, 0);
    checkOutput("rst hits", bus.hit_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h005B, 5'd8, 4'd1, 3, 1'b1, 1'b0, "basic");
    repeat (3) @(negedge clk);
    checkOutput("basic hits_held", bus.hit_count, 4);

    applyStimulus(16'h000D, 5'd4, 4'd3, 0, 1'b0, 1'b0, "repeat");
    applyStimulus(16'hFFFF, 5'd0, 4'd2, 0, 1'b0, 1'b0, "len0");
    applyStimulus(16'hA5C3, 5'd20, 4'd1, 0, 1'b0, 1'b0, "clamp");
    applyStimulus(16'h0033, 5'd6, 4'd0, 2, 1'b0, 1'b0, "reps0");

    applyStimulus(16'h00B2, 5'd8, 4'd2, 5, 1'b1, 1'b1, "hold");
    applyStimulus(16'h0009, 5'd4, 4'd1, 0, 1'b0, 1'b0, "restart");

    // Abort a long transmission with an asynchronous reset between clock edges
    bus.pattern = 16'hFFFF;
    bus.len     = 5'd16;
    bus.reps    = 4'd1;
    bus.w       = 1'b1;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("abort busy_before", bus.busy, 1);
    checkOutput("abort hits_before", bus.hit_count, 4);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort j", bus.j, 0);
    checkOutput("abort j_valid", bus.j_valid, 0);
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort done", bus.done, 0);
    checkOutput("abort hits", bus.hit_count, 0);
    @(negedge clk);
    rst   = 1'b0;
    bus.w = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("abort no_done", bus.done, 0);
      checkOutput("abort no_valid", bus.j_valid, 0);
    end

    begin
      bit seenDone;
      seenDone     = 1'b0;
      bus2.pattern = 16'h1234;
      bus2.len     = 5'd16;
      bus2.reps    = 5'd20;
      bus2.w       = 1'b1;
      bus2.start   = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (bus2.done) begin
          seenDone = 1'b1;
          break;
        end
        @(negedge clk);
      end
      checkOutput("sat done_seen", seenDone, 1);
      checkOutput("sat hits_done", bus2.hit_count, 255);
      @(negedge clk);
      bus2.w = 1'b0;
      checkOutput("sat hits_idle", bus2.hit_count, 255);
      checkOutput("sat busy_off", bus2.busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
